phy_tx_serializer: RTL and testbench

PHY_TX_SERIALIZER -- requirements
Module: phy_tx_serializer

---
 rtl/phy_tx_serializer_if.sv | 9 +
 rtl/phy_tx_serializer.sv | 90 +++++++++
 tb/tb_phy_tx_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_serializer_if.sv
// Word handshake between a word source and the two-lane serializer.
interface phy_tx_serializer_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        in_ready;

    modport master (output data_in, output valid_in, input in_ready);
    modport slave  (input data_in, input valid_in, output in_ready);
endinterface

// File: rtl/phy_tx_serializer.sv
// Two-lane serializer: sends a comma preamble, then stripes 32-bit words as
// a high byte pair followed by a low byte pair, one bit per lane per clock.
module phy_tx_serializer #(
    parameter int unsigned N_SYNC = 4,
    parameter logic [7:0]  COMMA  = 8'hBC
) (
    input  logic               clk_32f,
    input  logic               reset,
    phy_tx_serializer_if.slave txIf,
    output logic               serial_data_0,
    output logic               serial_data_1,
    output logic               sync_done
);

    typedef enum logic [1:0] {SYNC, IDLE, DATA_HI, DATA_LO} state_e;

    localparam int SW = (N_SYNC < 1) ? 1 : $clog2(N_SYNC + 1);
    localparam logic [SW-1:0] NSYNC_C = SW'(N_SYNC);

    state_e        state_q;
    logic [2:0]    bitCnt_q;
    logic [SW-1:0] syncCnt_q;
    logic [31:0]   hold_q;
    logic [31:0]   cur_q;
    logic          holdFull_q;
    logic [7:0]    shift0_q;
    logic [7:0]    shift1_q;
    logic          syncDone_q;
    logic          accept;

    assign txIf.in_ready = !holdFull_q && !reset;
    assign accept        = txIf.valid_in && !holdFull_q;

    // Lane outputs are the MSB of each shift register, so they come straight from flops.
    assign serial_data_0 = shift0_q[7];
    assign serial_data_1 = shift1_q[7];
    assign sync_done     = syncDone_q;

    // A new byte pair is chosen whenever the bit counter wraps to zero; accept can
    // only happen while the holding register is empty, so it never races the clear.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= SYNC;
            bitCnt_q   <= 3'd0;
            syncCnt_q  <= '0;
            hold_q     <= 32'd0;
            cur_q      <= 32'd0;
            holdFull_q <= 1'b0;
            shift0_q   <= 8'd0;
            shift1_q   <= 8'd0;
            syncDone_q <= 1'b0;
        end else begin
            bitCnt_q <= bitCnt_q + 3'd1;

            if (accept) begin
                hold_q     <= txIf.data_in;
                holdFull_q <= 1'b1;
            end

            if (bitCnt_q == 3'd0) begin
                if (state_q == SYNC && syncCnt_q != NSYNC_C) begin
                    syncCnt_q <= syncCnt_q + SW'(1);
                    shift0_q  <= COMMA;
                    shift1_q  <= COMMA;
                end else begin
                    syncDone_q <= 1'b1;
                    if (state_q == DATA_HI) begin
                        state_q  <= DATA_LO;
                        shift0_q <= cur_q[15:8];
                        shift1_q <= cur_q[7:0];
                    end else if (holdFull_q) begin
                        state_q    <= DATA_HI;
                        cur_q      <= hold_q;
                        holdFull_q <= 1'b0;
                        shift0_q   <= hold_q[31:24];
                        shift1_q   <= hold_q[23:16];
                    end else begin
                        state_q  <= IDLE;
                        shift0_q <= COMMA;
                        shift1_q <= COMMA;
                    end
                end
            end else begin
                shift0_q <= {shift0_q[6:0], 1'b0};
                shift1_q <= {shift1_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: slot-indexed reference model of the expected
// lane bits, sync_done and in_ready, driven with directed and random words.
module tb_phy_tx_serializer;

    localparam int         N_SYNC = 4;
    localparam logic [7:0] COMMA  = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset;
    logic serial_data_0;
    logic serial_data_1;
    logic sync_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot index since reset release, pending/current words.
    int          mK;
    logic [31:0] mHold;
    logic [31:0] mCur;
    bit          mHoldFull;
    bit          mLastHi;
    bit          mLoActive;
    logic [7:0]  mByte0;
    logic [7:0]  mByte1;

    phy_tx_serializer_if txIf ();

    phy_tx_serializer #(
        .N_SYNC(N_SYNC),
        .COMMA (COMMA)
    ) dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .txIf         (txIf.slave),
        .serial_data_0(serial_data_0),
        .serial_data_1(serial_data_1),
        .sync_done    (sync_done)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic modelReset();
        mK        = 0;
        mHoldFull = 1'b0;
        mLastHi   = 1'b0;
        mLoActive = 1'b0;
        mHold     = 32'd0;
        mCur      = 32'd0;
        mByte0    = COMMA;
        mByte1    = COMMA;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        txIf.valid_in = 1'b0;
        repeat (n) @(posedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        modelReset();
    endtask

    // Drives one slot and returns what the lines must show after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, output bit acc,
                                 output logic [2:0] expLanes, output logic expReady);
        txIf.valid_in = v;
        txIf.data_in  = d;
        acc = v && !mHoldFull;
        if (mK % 8 == 0) begin
            mLoActive = 1'b0;
            if (mK < 8 * N_SYNC) begin
                mByte0 = COMMA;
                mByte1 = COMMA;
            end else if (mLastHi) begin
                mByte0    = mCur[15:8];
                mByte1    = mCur[7:0];
                mLastHi   = 1'b0;
                mLoActive = 1'b1;
            end else if (mHoldFull) begin
                mCur      = mHold;
                mHoldFull = 1'b0;
                mByte0    = mCur[31:24];
                mByte1    = mCur[23:16];
                mLastHi   = 1'b1;
            end else begin
                mByte0 = COMMA;
                mByte1 = COMMA;
            end
        end
        expLanes = {mByte0[7 - mK % 8], mByte1[7 - mK % 8], (mK >= 8 * N_SYNC)};
        if (acc) begin
            mHold     = d;
            mHoldFull = 1'b1;
        end
        expReady = !mHoldFull;
        mK++;
        @(posedge clk_32f);
        @(negedge clk_32f);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        txIf.valid_in = 1'b0;
        txIf.data_in  = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL reset_outputs cyc=%0d got=%b exp=000", i,
                         {serial_data_0, serial_data_1, sync_done});
            end
            checks++;
            if (txIf.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_in_ready cyc=%0d got=%b exp=0", i, txIf.in_ready);
            end
        end
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_preamble();
        bit acc;
        logic [2:0] e;
        logic r;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b0, 32'd0, acc, e, r);
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL preamble_lanes k=%0d got=%b exp=%b", mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL preamble_ready k=%0d got=%b exp=%b", mK - 1, txIf.in_ready, r);
            end
        end
    endtask

    task automatic test_single_word();
        bit acc;
        bit sent = 1'b0;
        logic [2:0] e;
        logic r;
        int startAt = 40 + int'($urandom_range(0, 15));
        applyReset(2);
        for (int i = 0; i < 100; i++) begin
            applyStimulus((i >= startAt) && !sent, 32'hF0A53C96, acc, e, r);
            if (acc) sent = 1'b1;
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL single_lanes k=%0d got=%b exp=%b", mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL single_ready k=%0d got=%b exp=%b", mK - 1, txIf.in_ready, r);
            end
        end
        checks++;
        if (!sent) begin
            failures++;
            $display("[TB] FAIL single_accept got=0 exp=1");
        end
    endtask

    task automatic test_sync_accept();
        bit acc;
        bit sent = 1'b0;
        logic [2:0] e;
        logic r;
        applyReset(2);
        for (int i = 0; i < 60; i++) begin
            applyStimulus((i >= 2) && !sent, 32'h12345678, acc, e, r);
            if (acc) sent = 1'b1;
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL syncacc_lanes k=%0d got=%b exp=%b", mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL syncacc_ready k=%0d got=%b exp=%b", mK - 1, txIf.in_ready, r);
            end
        end
        checks++;
        if (!sent) begin
            failures++;
            $display("[TB] FAIL syncacc_accept got=0 exp=1");
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] w0, input logic [31:0] w1, input string tag);
        bit acc;
        logic [2:0] e;
        logic r;
        logic [31:0] q[$];
        q.push_back(w0);
        q.push_back(w1);
        applyReset(2);
        for (int i = 0; i < 110; i++) begin
            applyStimulus((i >= 36) && (q.size() > 0), (q.size() > 0) ? q[0] : 32'd0, acc, e, r);
            if (acc) void'(q.pop_front());
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL %s_lanes k=%0d got=%b exp=%b", tag, mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL %s_ready k=%0d got=%b exp=%b", tag, mK - 1, txIf.in_ready, r);
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_accept left=%0d exp=0", tag, q.size());
        end
    endtask

    task automatic test_reset_midword();
        bit acc;
        bit found = 1'b0;
        logic [2:0] e;
        logic r;
        logic [31:0] q[$];
        q.push_back(32'hCAFEF00D);
        q.push_back(32'h5A5AA5A5);
        applyReset(2);
        for (int i = 0; i < 120 && !found; i++) begin
            applyStimulus((i >= 34) && (q.size() > 0), (q.size() > 0) ? q[0] : 32'd0, acc, e, r);
            if (acc) void'(q.pop_front());
            if (mLoActive && ((mK - 1) % 8 == 5)) found = 1'b1;
        end
        checks++;
        if (!found || !mHoldFull) begin
            failures++;
            $display("[TB] FAIL midword_setup found=%0d held=%0d exp=1/1", found, mHoldFull);
        end
        reset = 1'b1;
        txIf.valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            checks++;
            if ({serial_data_0, serial_data_1, sync_done, txIf.in_ready} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL midword_reset cyc=%0d got=%b exp=0000", i,
                         {serial_data_0, serial_data_1, sync_done, txIf.in_ready});
            end
        end
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 56; i++) begin
            applyStimulus(1'b0, 32'd0, acc, e, r);
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL midword_lanes k=%0d got=%b exp=%b", mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL midword_ready k=%0d got=%b exp=%b", mK - 1, txIf.in_ready, r);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        bit presenting = 1'b0;
        logic [31:0] word = 32'd0;
        logic [2:0] e;
        logic r;
        applyReset(2);
        for (int i = 0; i < 600; i++) begin
            if (!presenting && $urandom_range(0, 2) == 0) begin
                presenting = 1'b1;
                word = ($urandom_range(0, 7) == 0) ? {COMMA, 8'($urandom), COMMA, 8'($urandom)}
                                                   : 32'($urandom);
            end
            applyStimulus(presenting, word, acc, e, r);
            if (acc) presenting = 1'b0;
            checks++;
            if ({serial_data_0, serial_data_1, sync_done} !== e) begin
                failures++;
                $display("[TB] FAIL random_lanes k=%0d got=%b exp=%b", mK - 1,
                         {serial_data_0, serial_data_1, sync_done}, e);
            end
            checks++;
            if (txIf.in_ready !== r) begin
                failures++;
                $display("[TB] FAIL random_ready k=%0d got=%b exp=%b", mK - 1, txIf.in_ready, r);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        txIf.valid_in = 1'b0;
        txIf.data_in  = 32'd0;
        modelReset();
        test_reset();
        test_preamble();
        test_single_word();
        test_sync_accept();
        test_back_to_back(32'hAAAA5555, 32'h0F0F00FF, "b2b");
        test_back_to_back(32'hBCBCBCBC, 32'h00000000, "comma_data");
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
